// File: rtl/decode_stage_pipe.sv
`default_nettype none
// =============================================================================
// Module      : decode_stage_pipe
// Description : Decode stage holding the integer register file with write-first
//               bypass, the load-use hazard detector, the ID/EX pipeline register
//               and a saturating load-use bubble counter.
// Revision    : 1.0 - initial release
// =============================================================================
module decode_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic              ValidD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic              MemReadD,
    input  logic              UsesRs1D,
    input  logic              UsesRs2D,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    input  logic              StallE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic              MemReadE,
    output logic              ValidE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic [REG_AW-1:0] Rs1DH,
    output logic [REG_AW-1:0] Rs2DH,
    output logic              StallF,
    output logic              StallD,
    output logic [CNT_W-1:0]  BubbleCnt
);

    localparam int               NREGS     = 2**REG_AW;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [XLEN-1:0]   r_regs [NREGS];
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;
    logic              w_wrEn;
    logic              w_hazard;
    logic              w_hold;
    logic              w_capture;
    logic              w_countBubble;
    logic              w_unusedInstr;

    assign Rs1DH = InstrD[15 +: REG_AW];
    assign Rs2DH = InstrD[20 +: REG_AW];
    assign w_rd  = InstrD[7 +: REG_AW];
    assign w_unusedInstr = ^{InstrD[31:25], InstrD[14:12], InstrD[6:0]};

    assign w_wrEn = RegWriteW && (RdW != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_regs[RdW] <= ResultW;
        end
    end

    always_comb begin
        w_rd1 = r_regs[Rs1DH];
        if (Rs1DH == '0) begin
            w_rd1 = '0;
        end else if (w_wrEn && (RdW == Rs1DH)) begin
            w_rd1 = ResultW;
        end
    end

    always_comb begin
        w_rd2 = r_regs[Rs2DH];
        if (Rs2DH == '0) begin
            w_rd2 = '0;
        end else if (w_wrEn && (RdW == Rs2DH)) begin
            w_rd2 = ResultW;
        end
    end

    assign w_hazard = ValidD && ValidE && MemReadE && (RdE != '0) &&
                      ((UsesRs1D && (Rs1DH == RdE)) || (UsesRs2D && (Rs2DH == RdE)));

    assign StallF = w_hazard | StallE;
    assign StallD = w_hazard | StallE;

    // Flush beats stall; anything that neither holds nor captures is a bubble.
    assign w_hold        = StallE && !FlushE;
    assign w_capture     = !FlushE && !StallE && !w_hazard && ValidD;
    assign w_countBubble = !FlushE && !StallE && w_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            CtrlE    <= '0;
            MemReadE <= 1'b0;
            ValidE   <= 1'b0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (!w_hold) begin
            RD1E     <= w_capture ? w_rd1    : '0;
            RD2E     <= w_capture ? w_rd2    : '0;
            PCE      <= w_capture ? PCD      : '0;
            PCPlus4E <= w_capture ? PCPlus4D : '0;
            ImmExtE  <= w_capture ? ImmExtD  : '0;
            CtrlE    <= w_capture ? CtrlD    : '0;
            MemReadE <= w_capture && MemReadD;
            ValidE   <= w_capture;
            Rs1E     <= w_capture ? Rs1DH    : '0;
            Rs2E     <= w_capture ? Rs2DH    : '0;
            RdE      <= w_capture ? w_rd     : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BubbleCnt <= '0;
        end else if (w_countBubble && (BubbleCnt != c_CNT_MAX)) begin
            BubbleCnt <= BubbleCnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
